mem_access: RTL

- Memory stage of the five-stage pipeline. Sits directly downstream of the execute stage and upstream of writeback.
- Registers the execute-stage results (EX/MEM boundary) and passes ALU and HI/LO results through.
- For loads and stores, runs a req/ack handshake with the data memory, generating byte strobes and extending load data.
- Raises a pipeline stall while an access is outstanding and flags misaligned addresses.

---
 rtl/mem_access.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory stage of the five-stage pipeline (EX/MEM boundary register).
// Passes ALU and HI/LO results to writeback. For loads and stores it runs a
// req/ack handshake with data memory, builds byte strobes and replicated store
// data, and extends load data. Holds upstream via stall_req while an access is
// outstanding and flags misaligned addresses.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   stall                     downstream freeze of wb_*/exc_* registers
//   in_valid .. whilo_in      execute-stage results and control
//   data_*                    data memory handshake
//   stall_req                 hold upstream stages
//   wb_*                      registered results to writeback
//   exc_adel/ades/badvaddr    address-error flags and faulting address
module mem_access #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        write_reg,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              whilo_in,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_ack,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall_req,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_waddr,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] exc_badvaddr
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e state_q, state_d;

    // Access registers latched on accept
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d, wr_q, wr_d, mtr_q, mtr_d, we_q, we_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [3:0]        strb_q, strb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, hi_q, hi_d, lo_q, lo_d, ldbuf_q, ldbuf_d;
    logic              whilo_q, whilo_d;

    // Writeback / exception registers
    logic              wb_valid_d, wb_we_d, wb_whilo_d, exc_adel_d, exc_ades_d;
    logic [DATA_W-1:0] wb_data_d, wb_hi_d, wb_lo_d;
    logic [4:0]        wb_waddr_d;
    logic [ADDR_W-1:0] exc_badvaddr_d;

    logic              is_mem, aligned, accept;
    logic [3:0]        strb_in;
    logic [DATA_W-1:0] wdata_in, ld_val, mem_result;

    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        unique case (sz)
            2'b00:   load_ext = {{24{sgn & b[7]}}, b};
            2'b01:   load_ext = {{16{sgn & h[15]}}, h};
            default: load_ext = rd;
        endcase
    endfunction

    always_comb begin
        is_mem = mem_read_in | mem_write_in;
        unique case (mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_result[0];
            default: aligned = (alu_result[1:0] == 2'b00);
        endcase
        accept = in_valid & is_mem & aligned;
        unique case (mem_size)
            2'b00: begin
                strb_in  = 4'b0001 << alu_result[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb_in  = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            default: begin
                strb_in  = 4'b1111;
                wdata_in = store_data;
            end
        endcase
        if (!mem_write_in) strb_in = 4'b0000;
        ld_val     = load_ext(data_rdata, addr_q[1:0], size_q, sign_q);
        // Stores never have mem_to_reg set, so they fall through to the address.
        mem_result = mtr_q ? ld_val : addr_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q; size_d = size_q; sign_d = sign_q; wr_d = wr_q; mtr_d = mtr_q;
        we_d = we_q; waddr_d = waddr_q; strb_d = strb_q; wdata_d = wdata_q;
        hi_d = hi_q; lo_d = lo_q; whilo_d = whilo_q; ldbuf_d = ldbuf_q;
        wb_valid_d = wb_valid; wb_data_d = wb_data; wb_waddr_d = wb_waddr; wb_we_d = wb_we;
        wb_hi_d = wb_hi; wb_lo_d = wb_lo; wb_whilo_d = wb_whilo;
        exc_adel_d = exc_adel; exc_ades_d = exc_ades; exc_badvaddr_d = exc_badvaddr;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccess;
                    addr_d = alu_result; size_d = mem_size; sign_d = mem_sign;
                    wr_d = mem_write_in; mtr_d = mem_to_reg_in; we_d = reg_write_in;
                    waddr_d = write_reg; strb_d = strb_in; wdata_d = wdata_in;
                    hi_d = hi_in; lo_d = lo_in; whilo_d = whilo_in;
                end
                if (!stall) begin
                    if (accept) begin
                        // Bubble while the access is in flight
                        wb_valid_d = 1'b0; wb_we_d = 1'b0; wb_whilo_d = 1'b0;
                        exc_adel_d = 1'b0; exc_ades_d = 1'b0;
                    end else begin
                        wb_valid_d = in_valid; wb_data_d = alu_result; wb_waddr_d = write_reg;
                        wb_hi_d = hi_in; wb_lo_d = lo_in;
                        wb_we_d = reg_write_in & in_valid;
                        wb_whilo_d = whilo_in & in_valid;
                        exc_adel_d = 1'b0; exc_ades_d = 1'b0; exc_badvaddr_d = '0;
                        if (in_valid && is_mem) begin
                            // Misaligned: address error instead of an access
                            wb_we_d = 1'b0; wb_whilo_d = 1'b0;
                            exc_adel_d = mem_read_in & ~mem_write_in;
                            exc_ades_d = mem_write_in;
                            exc_badvaddr_d = alu_result;
                        end
                    end
                end
            end
            StAccess: begin
                if (data_ack) begin
                    if (stall) begin
                        state_d = StDone;
                        ldbuf_d = mem_result;
                    end else begin
                        state_d = StIdle;
                        wb_valid_d = 1'b1; wb_data_d = mem_result; wb_waddr_d = waddr_q;
                        wb_we_d = we_q & ~wr_q; wb_hi_d = hi_q; wb_lo_d = lo_q;
                        wb_whilo_d = whilo_q; exc_adel_d = 1'b0; exc_ades_d = 1'b0;
                        exc_badvaddr_d = '0;
                    end
                end else if (!stall) begin
                    wb_valid_d = 1'b0; wb_we_d = 1'b0; wb_whilo_d = 1'b0;
                    exc_adel_d = 1'b0; exc_ades_d = 1'b0;
                end
            end
            StDone: begin
                if (!stall) begin
                    state_d = StIdle;
                    wb_valid_d = 1'b1; wb_data_d = ldbuf_q; wb_waddr_d = waddr_q;
                    wb_we_d = we_q & ~wr_q; wb_hi_d = hi_q; wb_lo_d = lo_q;
                    wb_whilo_d = whilo_q; exc_adel_d = 1'b0; exc_ades_d = 1'b0;
                    exc_badvaddr_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q <= '0; size_q <= '0; sign_q <= 1'b0; wr_q <= 1'b0; mtr_q <= 1'b0;
            we_q <= 1'b0; waddr_q <= '0; strb_q <= '0; wdata_q <= '0;
            hi_q <= '0; lo_q <= '0; whilo_q <= 1'b0; ldbuf_q <= '0;
            wb_valid <= 1'b0; wb_data <= '0; wb_waddr <= '0; wb_we <= 1'b0;
            wb_hi <= '0; wb_lo <= '0; wb_whilo <= 1'b0;
            exc_adel <= 1'b0; exc_ades <= 1'b0; exc_badvaddr <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d; size_q <= size_d; sign_q <= sign_d; wr_q <= wr_d; mtr_q <= mtr_d;
            we_q <= we_d; waddr_q <= waddr_d; strb_q <= strb_d; wdata_q <= wdata_d;
            hi_q <= hi_d; lo_q <= lo_d; whilo_q <= whilo_d; ldbuf_q <= ldbuf_d;
            wb_valid <= wb_valid_d; wb_data <= wb_data_d; wb_waddr <= wb_waddr_d;
            wb_we <= wb_we_d; wb_hi <= wb_hi_d; wb_lo <= wb_lo_d; wb_whilo <= wb_whilo_d;
            exc_adel <= exc_adel_d; exc_ades <= exc_ades_d; exc_badvaddr <= exc_badvaddr_d;
        end
    end

    assign data_req   = (state_q == StAccess);
    assign data_wr    = wr_q;
    assign data_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_wstrb = strb_q;
    assign data_wdata = wdata_q;
    assign stall_req  = ((state_q == StIdle) & accept) |
                        ((state_q == StAccess) & ~data_ack) |
                        (state_q == StDone);

endmodule
